// File: rtl/dm_cache.sv
// Direct-mapped write-through byte cache between the MIU and backing memory.
// Read hits are served locally; read misses and all writes go to memory.
module dm_cache #(
  parameter int ADDR_W    = 16,
  parameter int NUM_LINES = 16
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              cache_req_valid,
  output logic              cache_req_ready,
  input  logic              cache_req_we,
  input  logic [ADDR_W-1:0] cache_req_addr,
  input  logic [7:0]        cache_req_write,
  output logic              cache_resp_valid,
  output logic [7:0]        cache_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [7:0]        mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [7:0]        mem_resp_rdata,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = ADDR_W - INDEX_W;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOOKUP   = 3'd1;
  localparam logic [2:0] MEM_REQ  = 3'd2;
  localparam logic [2:0] MEM_WAIT = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  logic [2:0]           state;
  logic                 req_we;
  logic [ADDR_W-1:0]    req_addr;
  logic [7:0]           req_wdata;
  logic [NUM_LINES-1:0] line_valid;
  logic [TAG_W-1:0]     line_tag  [NUM_LINES];
  logic [7:0]           line_data [NUM_LINES];
  logic [INDEX_W-1:0]   idx;
  logic [TAG_W-1:0]     tag;
  logic                 hit;

  assign idx = req_addr[INDEX_W-1:0];
  assign tag = req_addr[ADDR_W-1:INDEX_W];
  assign hit = line_valid[idx] && (line_tag[idx] == tag);

  assign cache_req_ready  = (state == IDLE);
  assign cache_resp_valid = (state == RESP);
  assign mem_req_valid    = (state == MEM_REQ);

  // Control FSM, request capture, valid bits, counters and output registers
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state           <= IDLE;
      req_we          <= 1'b0;
      req_addr        <= '0;
      req_wdata       <= '0;
      line_valid      <= '0;
      cache_resp_data <= '0;
      mem_req_we      <= 1'b0;
      mem_req_addr    <= '0;
      mem_req_wdata   <= '0;
      hit_count       <= '0;
      miss_count      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cache_req_valid) begin
            req_we    <= cache_req_we;
            req_addr  <= cache_req_addr;
            req_wdata <= cache_req_write;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!req_we && hit) begin
            cache_resp_data <= line_data[idx];
            if (hit_count != 16'hFFFF)
              hit_count <= hit_count + 16'd1;
            state <= RESP;
          end else begin
            if (!req_we && miss_count != 16'hFFFF)
              miss_count <= miss_count + 16'd1;
            mem_req_we    <= req_we;
            mem_req_addr  <= req_addr;
            mem_req_wdata <= req_wdata;
            state         <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (mem_req_ready)
            state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_resp_valid) begin
            if (!req_we) begin
              line_valid[idx] <= 1'b1;
              cache_resp_data <= mem_resp_rdata;
            end else begin
              cache_resp_data <= 8'h00;
            end
            state <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Line tag/data storage: fill on read miss, update data on write hit
  always_ff @(posedge clk) begin
    if (resetN && state == MEM_WAIT && mem_resp_valid) begin
      if (!req_we) begin
        line_tag[idx]  <= tag;
        line_data[idx] <= mem_resp_rdata;
      end else if (hit) begin
        line_data[idx] <= req_wdata;
      end
    end
  end

endmodule
